// File: rtl/data_memory_master.sv
// Burst initiator for the data memory: splits write/read burst commands into
// single-word accesses on one addr/dataIn/writeEnable/data memory port.
module data_memory_master #(
    parameter int WIDTH        = 5,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 4,
    parameter int ADDR_STRIDE  = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [WIDTH-1:0]      wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_we,
    input  logic [WIDTH-1:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_WAIT,
        RD_HOLD,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [1:0]            LAT_LAST = 2'(READ_LATENCY);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_isWrite;
    logic [1:0]            r_latCnt;
    logic [WIDTH-1:0]      r_rdData;
    logic                  r_cmdReady;
    logic                  r_wrReady;
    logic                  r_rdValid;
    logic                  r_done;
    logic                  r_addrEn;

    logic                  w_lastWord;
    logic                  w_writePhase;

    assign w_lastWord   = (r_remaining == LEN_WIDTH'(1));
    assign w_writePhase = r_wrReady & r_isWrite;

    // The memory samples writeEnable on the same edge, so the write strobe
    // follows wr_valid combinationally while the burst sits in WRITE.
    assign mem_we    = w_writePhase & wr_valid;
    assign mem_wdata = w_writePhase ? wr_data : '0;
    assign mem_addr  = r_addrEn ? r_curAddr : '0;

    assign cmd_ready = r_cmdReady;
    assign wr_ready  = r_wrReady;
    assign rd_valid  = r_rdValid;
    assign rd_data   = r_rdData;
    assign done      = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_curAddr   <= '0;
            r_remaining <= '0;
            r_isWrite   <= 1'b0;
            r_latCnt    <= '0;
            r_rdData    <= '0;
            r_cmdReady  <= 1'b1;
            r_wrReady   <= 1'b0;
            r_rdValid   <= 1'b0;
            r_done      <= 1'b0;
            r_addrEn    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_curAddr   <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_isWrite   <= cmd_write;
                        r_latCnt    <= '0;
                        r_cmdReady  <= 1'b0;
                        if (cmd_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (cmd_write) begin
                            r_state   <= WRITE;
                            r_wrReady <= 1'b1;
                            r_addrEn  <= 1'b1;
                        end else begin
                            r_state  <= RD_WAIT;
                            r_addrEn <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (wr_valid) begin
                        r_curAddr   <= r_curAddr + STRIDE;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        if (w_lastWord) begin
                            r_state   <= DONE;
                            r_wrReady <= 1'b0;
                            r_addrEn  <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end

                // Address is held READ_LATENCY+1 cycles; the last edge captures the word.
                RD_WAIT: begin
                    if (r_latCnt == LAT_LAST) begin
                        r_rdData  <= mem_rdata;
                        r_rdValid <= 1'b1;
                        r_latCnt  <= '0;
                        r_state   <= RD_HOLD;
                    end else begin
                        r_latCnt <= r_latCnt + 2'd1;
                    end
                end

                RD_HOLD: begin
                    if (rd_ready) begin
                        r_curAddr   <= r_curAddr + STRIDE;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        r_rdValid   <= 1'b0;
                        r_latCnt    <= '0;
                        if (w_lastWord) begin
                            r_state  <= DONE;
                            r_addrEn <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end

                DONE: begin
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_cmdReady <= 1'b1;
                end

                default: begin
                    r_state    <= IDLE;
                    r_cmdReady <= 1'b1;
                    r_wrReady  <= 1'b0;
                    r_rdValid  <= 1'b0;
                    r_done     <= 1'b0;
                    r_addrEn   <= 1'b0;
                end
            endcase
        end
    end

endmodule
